// File: rtl/cnt_seq_pkg.sv
// Shared types and default sizes for the counter command sequencer.
package cnt_seq_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_CLEAR     = 2'b00,
    OP_LOAD      = 2'b01,
    OP_STEP_UP   = 2'b10,
    OP_STEP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_seq.sv
// Command sequencer that drives an external loadable up/down counter one
// command at a time and reports the final value with a wrap flag.
//
// state  | meaning
// IDLE   | ready for a command; counter held by self-reload
// ISSUE  | one-cycle CLEAR or LOAD pulse to the counter
// RUN    | counter stepping, one step per cycle, N cycles
// SETTLE | counter held; capture result and pulse done
module cnt_seq
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wrapped,
  output logic             cnt_rst,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic [WIDTH-1:0] cnt_loadin,
  input  logic [WIDTH-1:0] cnt_y
);

  localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  ALL1  = '1;
  localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

  state_e            state, state_nxt;
  logic [STEP_W-1:0] remaining, remaining_nxt;
  logic              wrap_acc, wrap_acc_nxt;
  logic              rst_nxt, load_nxt, up_nxt, done_nxt, wrapped_nxt;
  logic [WIDTH-1:0]  loadin_nxt, result_nxt, y_after;
  logic [STEP_W-1:0] n_cmd;
  logic              wrap_hit;

  assign cmd_ready = rst_n && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign n_cmd     = cmd_data[STEP_W-1:0];
  assign wrap_hit  = (state == ST_RUN) && (cnt_up ? (cnt_y == ALL1) : (cnt_y == '0));

  // Value the counter will hold after the coming edge, so a self-reload
  // registered now reloads the post-edge value rather than a stale one.
  always_comb begin
    y_after = cnt_y - ONE;
    if (cnt_rst)       y_after = '0;
    else if (cnt_load) y_after = cnt_loadin;
    else if (cnt_up)   y_after = cnt_y + ONE;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    wrap_acc_nxt  = wrap_acc;
    rst_nxt       = 1'b0;
    load_nxt      = 1'b1;
    up_nxt        = 1'b0;
    loadin_nxt    = y_after;
    done_nxt      = 1'b0;
    result_nxt    = result;
    wrapped_nxt   = wrapped;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wrap_acc_nxt = 1'b0;
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              state_nxt = ST_ISSUE;
              rst_nxt   = 1'b1;
              load_nxt  = 1'b0;
            end
            OP_LOAD: begin
              state_nxt  = ST_ISSUE;
              loadin_nxt = cmd_data;
            end
            default: begin
              if (n_cmd != '0) begin
                state_nxt     = ST_RUN;
                remaining_nxt = n_cmd;
                load_nxt      = 1'b0;
                up_nxt        = (op_e'(cmd_op) == OP_STEP_UP);
              end else begin
                state_nxt = ST_SETTLE;
              end
            end
          endcase
        end
      end
      ST_ISSUE: state_nxt = ST_SETTLE;
      ST_RUN: begin
        if (wrap_hit) wrap_acc_nxt = 1'b1;
        remaining_nxt = remaining - ONE_S;
        if (remaining == ONE_S) begin
          state_nxt = ST_SETTLE;
        end else begin
          load_nxt = 1'b0;
          up_nxt   = cnt_up;
        end
      end
      ST_SETTLE: begin
        state_nxt   = ST_IDLE;
        result_nxt  = cnt_y;
        wrapped_nxt = wrap_acc;
        done_nxt    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      wrap_acc   <= 1'b0;
      cnt_rst    <= 1'b1;
      cnt_load   <= 1'b0;
      cnt_up     <= 1'b0;
      cnt_loadin <= '0;
      done       <= 1'b0;
      result     <= '0;
      wrapped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      wrap_acc   <= wrap_acc_nxt;
      cnt_rst    <= rst_nxt;
      cnt_load   <= load_nxt;
      cnt_up     <= up_nxt;
      cnt_loadin <= loadin_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
      wrapped    <= wrapped_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_seq.sv
// Self-checking bench: cnt_seq driving a behavioural 8-bit up/down counter.
module tb_cnt_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       busy, done, wrapped;
  logic [7:0] result;
  logic       cnt_rst, cnt_load, cnt_up;
  logic [7:0] cnt_loadin, y;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_y;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_rst)       y <= 8'h00;
    else if (cnt_load) y <= cnt_loadin;
    else if (cnt_up)   y <= y + 8'h01;
    else               y <= y - 8'h01;
  end

  cnt_seq #(.WIDTH(8), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .busy(busy), .done(done), .result(result), .wrapped(wrapped),
    .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_loadin(cnt_loadin),
    .cnt_y(y)
  );

  // Offer a command, wait for acceptance, return edges from accept until done.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, output int lat);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin @(posedge clk); #1; lat++; end
  endtask

  // Reference: expected latency, result and wrap for a command from value v.
  task automatic model(input logic [1:0] op, input logic [7:0] d, input logic [7:0] v,
                       output int lat, output logic [7:0] r, output logic w);
    int n;
    n = d;
    w = 1'b0;
    case (op)
      2'b00: begin lat = 2; r = 8'h00; end
      2'b01: begin lat = 2; r = d; end
      2'b10: begin lat = (n == 0) ? 1 : n + 1; r = 8'(int'(v) + n); w = (int'(v) + n) > 255; end
      default: begin lat = (n == 0) ? 1 : n + 1; r = v - d; w = n > int'(v); end
    endcase
  endtask

  task automatic check_cmd(input string name, input logic [1:0] op, input logic [7:0] d);
    int lat, elat;
    logic [7:0] er;
    logic ew;
    model(op, d, exp_y, elat, er, ew);
    run_cmd(op, d, lat);
    checks++; if (lat !== elat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
    checks++; if (result !== er) begin failures++; $display("FAIL %s result got=%02h exp=%02h", name, result, er); end
    checks++; if (wrapped !== ew) begin failures++; $display("FAIL %s wrapped got=%0b exp=%0b", name, wrapped, ew); end
    checks++; if (y !== er) begin failures++; $display("FAIL %s counter_y got=%02h exp=%02h", name, y, er); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL %s ready_with_done got=%0b exp=1", name, cmd_ready); end
    exp_y = er;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cnt_rst, cnt_load, cnt_up, cnt_loadin} !== {3'b100, 8'h00}) begin
      failures++; $display("FAIL reset_ctrl got=%b/%b/%b/%02h exp=1/0/0/00", cnt_rst, cnt_load, cnt_up, cnt_loadin); end
    checks++; if ({done, wrapped, busy, cmd_ready, result} !== {4'b0000, 8'h00}) begin
      failures++; $display("FAIL reset_status got=%b%b%b%b/%02h exp=0000/00", done, wrapped, busy, cmd_ready, result); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (y !== 8'h00) begin failures++; $display("FAIL reset_counter_clear got=%02h exp=00", y); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%0b exp=1", cmd_ready); end
    exp_y = 8'h00;
  endtask

  task automatic test_directed();
    check_cmd("load_3c", 2'b01, 8'h3C);
    check_cmd("load_fe", 2'b01, 8'hFE);
    check_cmd("up3_wrap", 2'b10, 8'd3);
    check_cmd("clear", 2'b00, 8'h77);
    check_cmd("down1_wrap", 2'b11, 8'd1);
    check_cmd("down0", 2'b11, 8'd0);
  endtask

  task automatic test_back_to_back();
    int lat, early;
    check_cmd("hold_load", 2'b01, 8'h20);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'd10;
    @(posedge clk); #1;
    cmd_op = 2'b01;
    lat = 0; early = 0;
    while (!done && lat < 200) begin
      @(negedge clk); cmd_data = 8'($urandom);
      @(posedge clk); #1; lat++;
      if (!done && cmd_ready) early++;
    end
    cmd_valid = 1'b0;
    checks++; if (lat !== 11) begin failures++; $display("FAIL hold_latency got=%0d exp=11", lat); end
    checks++; if (early !== 0) begin failures++; $display("FAIL hold_ready_while_busy got=%0d exp=0", early); end
    checks++; if (result !== 8'h2A) begin failures++; $display("FAIL hold_result got=%02h exp=2a", result); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_with_done got=%0b exp=1", cmd_ready); end
    early = 0;
    repeat (20) begin @(posedge clk); #1; if (y !== 8'h2A || busy !== 1'b0) early++; end
    checks++; if (early !== 0) begin failures++; $display("FAIL idle_hold bad_cycles=%0d exp=0 y=%02h", early, y); end
    exp_y = 8'h2A;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = (op >= 2'b10) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      if (i % 7 == 3) begin op = 2'b01; d = 8'(253 + (i % 3)); end
      check_cmd($sformatf("rand%0d", i), op, d);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'd50;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({busy, cmd_ready, done, cnt_rst} !== 4'b0001) begin
      failures++; $display("FAIL midrst_status got=%b%b%b%b exp=0001", busy, cmd_ready, done, cnt_rst); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (y !== 8'h00) begin failures++; $display("FAIL midrst_counter got=%02h exp=00", y); end
    dones = 0;
    repeat (60) begin @(posedge clk); #1; if (done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    exp_y = 8'h00;
    check_cmd("midrst_load", 2'b01, 8'hA5);
    check_cmd("midrst_down", 2'b11, 8'd6);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
